// File: rtl/keyboard_pkg.sv
// Scancode/ASCII constants and the PS/2 set-2 make-code to ASCII lookup
// shared by the keyboard FIFO. Both the plain and the shifted table live here.
package keyboard_pkg;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_MINUS  = 8'h4E;
  localparam logic [7:0] SC_EQUAL  = 8'h55;
  localparam logic [7:0] SC_COMMA  = 8'h41;
  localparam logic [7:0] SC_PERIOD = 8'h49;
  localparam logic [7:0] SC_SLASH  = 8'h4A;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Returns ASCII_NUL for any code outside the mapped set.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc, input logic shift);
    logic [7:0] base;
    logic [7:0] shifted;
    case (sc)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
      8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
      8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
      8'h46: base = 8'h39;
      SC_SPACE:  base = ASCII_SPACE;
      SC_ENTER:  base = ASCII_CR;
      SC_BKSP:   base = ASCII_BS;
      SC_TAB:    base = ASCII_TAB;
      SC_MINUS:  base = 8'h2D;
      SC_EQUAL:  base = 8'h3D;
      SC_COMMA:  base = 8'h2C;
      SC_PERIOD: base = 8'h2E;
      SC_SLASH:  base = 8'h2F;
      default:   base = ASCII_NUL;
    endcase

    // Shifted table is derived from the plain character, US keyboard layout.
    shifted = base;
    if (base >= 8'h61 && base <= 8'h7A) begin
      shifted = base - 8'h20;
    end else begin
      case (base)
        8'h31: shifted = 8'h21;  8'h32: shifted = 8'h40;  8'h33: shifted = 8'h23;
        8'h34: shifted = 8'h24;  8'h35: shifted = 8'h25;  8'h36: shifted = 8'h5E;
        8'h37: shifted = 8'h26;  8'h38: shifted = 8'h2A;  8'h39: shifted = 8'h28;
        8'h30: shifted = 8'h29;  8'h2D: shifted = 8'h5F;  8'h3D: shifted = 8'h2B;
        8'h2C: shifted = 8'h3C;  8'h2E: shifted = 8'h3E;  8'h2F: shifted = 8'h3F;
        default: shifted = base;
      endcase
    end
    return shift ? shifted : base;
  endfunction

endpackage

// File: rtl/ps2_ascii_fifo_if.sv
// Receiver-side and bus-side signals of the keyboard character FIFO.
// master = receiver + bus decoder, slave = ps2_ascii_fifo.
interface ps2_ascii_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       scancode;
  logic             oflag;
  logic             on_shift;
  logic             rd_en;
  logic             clr_ovf;
  logic [7:0]       rd_data;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output scancode, oflag, on_shift, rd_en, clr_ovf,
    input  rd_data, valid, count, overflow
  );

  modport slave (
    input  scancode, oflag, on_shift, rd_en, clr_ovf,
    output rd_data, valid, count, overflow
  );
endinterface

// File: rtl/kbd_fifo.sv
// Generic show-ahead FIFO: dout always presents the head entry.
// A push while full is accepted only when a pop frees a slot the same cycle.
module kbd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_ascii_fifo.sv
// Translates PS/2 make-codes to ASCII and buffers them for software reads.
// Define KBD_SHIFT_MAP_EN to honour on_shift; otherwise only lowercase/plain.
module ps2_ascii_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  ps2_ascii_fifo_if.slave bus
);
  import keyboard_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       ascii;
  logic [7:0]       head;
  logic             push_req;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_q;
  logic [CNT_W-1:0] fifo_count;

`ifdef KBD_SHIFT_MAP_EN
  assign ascii = sc_to_ascii(bus.scancode, bus.on_shift);
`else
  logic unused_shift;
  assign unused_shift = bus.on_shift;
  assign ascii = sc_to_ascii(bus.scancode, 1'b0);
`endif

  assign push_req = bus.oflag && (ascii != ASCII_NUL);
  assign pop_req  = bus.rd_en && !fifo_empty;

  kbd_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop_req),
    .din   (ascii),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A drop only happens when full with no pop freeing a slot; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.valid    = !fifo_empty;
  assign bus.rd_data  = fifo_empty ? ASCII_NUL : head;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Self-checking bench for ps2_ascii_fifo: directed scenarios plus random traffic
// against a queue-based reference model built from keyboard layout strings.
module tb_ps2_ascii_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef KBD_SHIFT_MAP_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_ascii_fifo_if #(.DEPTH(DEPTH)) tif ();

  ps2_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  // Layout description: scancodes in alphabetical/numeric order plus strings.
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
  logic [7:0] punct_sc [5]  = '{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A};
  logic [7:0] ctrl_sc  [4]  = '{8'h29, 8'h5A, 8'h66, 8'h0D};
  logic [7:0] ctrl_ch  [4]  = '{8'h20, 8'h0D, 8'h08, 8'h09};
  string digit_plain = "0123456789";
  string digit_shift = ")!@#$%^&*(";
  string punct_plain = "-=,./";
  string punct_shift = "_+<>?";

  logic [7:0] model_q [$];
  logic [7:0] mapped_q [$];
  bit         model_ovf;
  logic [7:0] exp_head;
  logic [7:0] dut_head;
  bit         popped;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [7:0] model_ascii(input logic [7:0] sc, input bit sh);
    bit up;
    up = SHIFT_EN && sh;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == sc) return up ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == sc) return up ? digit_shift[i] : digit_plain[i];
    for (int i = 0; i < 5; i++)
      if (punct_sc[i] == sc) return up ? punct_shift[i] : punct_plain[i];
    for (int i = 0; i < 4; i++)
      if (ctrl_sc[i] == sc) return ctrl_ch[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rand_mapped();
    return mapped_q[$urandom_range(0, mapped_q.size() - 1)];
  endfunction

  // Drives one clock cycle of stimulus and advances the reference model.
  task automatic applyStimulus(input bit of, input logic [7:0] sc, input bit sh,
                               input bit rd, input bit clr);
    logic [7:0] a;
    bit do_pop, do_push, set_ovf;
    tif.oflag = of; tif.scancode = sc; tif.on_shift = sh;
    tif.rd_en = rd; tif.clr_ovf = clr;
    a        = model_ascii(sc, sh);
    dut_head = tif.rd_data;
    exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    do_pop   = rd && (model_q.size() > 0);
    do_push  = of && (a != 8'h00);
    set_ovf  = do_push && (model_q.size() == DEPTH) && !do_pop;
    @(posedge clk); #1;
    tif.oflag = 1'b0; tif.rd_en = 1'b0; tif.clr_ovf = 1'b0;
    if (do_pop) void'(model_q.pop_front());
    if (do_push && !set_ovf) model_q.push_back(a);
    if (set_ovf) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    popped = do_pop;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (tif.count !== '0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d want 0", tif.count); end
    n_vec++; if (tif.valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", tif.valid); end
    n_vec++; if (tif.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_rd_data: got %h want 00", tif.rd_data); end
    n_vec++; if (tif.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b want 0", tif.overflow); end
  endtask

  task automatic test_basic();
    applyStimulus(1, 8'h1C, 0, 0, 0);
    n_vec++; if (tif.valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_valid: got %b want 1", tif.valid); end
    n_vec++; if (tif.count !== CNT_W'(model_q.size())) begin n_bad++; $display("[TB] FAIL basic_count: got %0d want %0d", tif.count, model_q.size()); end
    n_vec++; if (tif.rd_data !== model_q[0]) begin n_bad++; $display("[TB] FAIL basic_head: got %h want %h", tif.rd_data, model_q[0]); end
    applyStimulus(0, 8'h00, 0, 1, 0);
    n_vec++; if (dut_head !== exp_head) begin n_bad++; $display("[TB] FAIL basic_read: got %h want %h", dut_head, exp_head); end
    n_vec++; if (tif.valid !== 1'b0 || tif.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL basic_empty: got valid=%b data=%h want 0/00", tif.valid, tif.rd_data); end
  endtask

  task automatic test_shift();
    applyStimulus(1, 8'h1C, 1, 0, 0);
    applyStimulus(1, 8'h16, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 0);
      n_vec++; if (dut_head !== exp_head) begin n_bad++; $display("[TB] FAIL shift_read%0d: got %h want %h", i, dut_head, exp_head); end
    end
  endtask

  task automatic test_unmapped();
    applyStimulus(1, 8'h0E, 0, 0, 0);
    applyStimulus(1, 8'h5A, 0, 0, 0);
    n_vec++; if (tif.count !== CNT_W'(model_q.size())) begin n_bad++; $display("[TB] FAIL unmapped_count: got %0d want %0d", tif.count, model_q.size()); end
    n_vec++; if (tif.rd_data !== model_q[0]) begin n_bad++; $display("[TB] FAIL unmapped_head: got %h want %h", tif.rd_data, model_q[0]); end
    n_vec++; if (tif.overflow !== model_ovf) begin n_bad++; $display("[TB] FAIL unmapped_ovf: got %b want %b", tif.overflow, model_ovf); end
    applyStimulus(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1, rand_mapped(), 1'($urandom_range(0, 1)), 0, 0);
    n_vec++; if (tif.count !== CNT_W'(DEPTH)) begin n_bad++; $display("[TB] FAIL ovf_count: got %0d want %0d", tif.count, DEPTH); end
    n_vec++; if (tif.overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag: got %b want 1", tif.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 0);
      n_vec++; if (dut_head !== exp_head) begin n_bad++; $display("[TB] FAIL ovf_drain%0d: got %h want %h", i, dut_head, exp_head); end
    end
    n_vec++; if (tif.valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_17th_absent: got valid=%b want 0", tif.valid); end
  endtask

  task automatic test_full_simul();
    applyStimulus(0, 8'h00, 0, 0, 1);
    n_vec++; if (tif.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_ovf: got %b want 0", tif.overflow); end
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, rand_mapped(), 0, 0, 0);
    applyStimulus(1, 8'h4A, 0, 1, 0);
    n_vec++; if (tif.count !== CNT_W'(DEPTH)) begin n_bad++; $display("[TB] FAIL simul_count: got %0d want %0d", tif.count, DEPTH); end
    n_vec++; if (tif.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL simul_ovf: got %b want 0", tif.overflow); end
    applyStimulus(1, 8'h1C, 0, 0, 1);
    n_vec++; if (tif.overflow !== model_ovf) begin n_bad++; $display("[TB] FAIL set_beats_clr: got %b want %b", tif.overflow, model_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 0);
      n_vec++; if (dut_head !== exp_head) begin n_bad++; $display("[TB] FAIL simul_drain%0d: got %h want %h", i, dut_head, exp_head); end
    end
    applyStimulus(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_empty_read();
    applyStimulus(0, 8'h00, 0, 1, 0);
    n_vec++; if (tif.count !== '0 || tif.valid !== 1'b0 || tif.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL empty_read: got count=%0d valid=%b data=%h want 0/0/00", tif.count, tif.valid, tif.rd_data); end
    applyStimulus(1, 8'h24, 0, 1, 0);
    n_vec++; if (tif.count !== CNT_W'(model_q.size()) || tif.rd_data !== model_q[0]) begin n_bad++; $display("[TB] FAIL empty_push_pop: got count=%0d data=%h want %0d/%h", tif.count, tif.rd_data, model_q.size(), model_q[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit of;
      logic [7:0] sc;
      of = ($urandom_range(0, 99) < 60);
      sc = ($urandom_range(0, 9) < 8) ? rand_mapped() : 8'($urandom);
      applyStimulus(of, sc, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 45),
                    ($urandom_range(0, 99) < 5));
      if (popped) begin
        n_vec++; if (dut_head !== exp_head) begin n_bad++; $display("[TB] FAIL rand_read c%0d: got %h want %h", c, dut_head, exp_head); end
      end
      n_vec++; if (tif.count !== CNT_W'(model_q.size())) begin n_bad++; $display("[TB] FAIL rand_count c%0d: got %0d want %0d", c, tif.count, model_q.size()); end
      n_vec++; if (tif.rd_data !== ((model_q.size() > 0) ? model_q[0] : 8'h00)) begin n_bad++; $display("[TB] FAIL rand_head c%0d: got %h", c, tif.rd_data); end
      n_vec++; if (tif.valid !== (model_q.size() > 0)) begin n_bad++; $display("[TB] FAIL rand_valid c%0d: got %b", c, tif.valid); end
      n_vec++; if (tif.overflow !== model_ovf) begin n_bad++; $display("[TB] FAIL rand_ovf c%0d: got %b want %b", c, tif.overflow, model_ovf); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1, rand_mapped(), 0, 0, 0);
    n_vec++; if (tif.count !== CNT_W'(5)) begin n_bad++; $display("[TB] FAIL areset_pre: got %0d want 5", tif.count); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (tif.count !== '0 || tif.valid !== 1'b0 || tif.rd_data !== 8'h00 || tif.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_now: got count=%0d valid=%b data=%h ovf=%b", tif.count, tif.valid, tif.rd_data, tif.overflow); end
    model_q.delete();
    model_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1, 8'h32, 0, 0, 0);
    n_vec++; if (tif.count !== CNT_W'(1) || tif.rd_data !== model_q[0]) begin n_bad++; $display("[TB] FAIL areset_first: got count=%0d data=%h want 1/%h", tif.count, tif.rd_data, model_q[0]); end
  endtask

  initial begin
    tif.scancode = 8'h00; tif.oflag = 1'b0; tif.on_shift = 1'b0;
    tif.rd_en = 1'b0; tif.clr_ovf = 1'b0;
    foreach (letter_sc[i]) mapped_q.push_back(letter_sc[i]);
    foreach (digit_sc[i])  mapped_q.push_back(digit_sc[i]);
    foreach (punct_sc[i])  mapped_q.push_back(punct_sc[i]);
    foreach (ctrl_sc[i])   mapped_q.push_back(ctrl_sc[i]);
    @(negedge clk);
    test_reset();
    test_basic();
    test_shift();
    test_unmapped();
    test_overflow();
    test_full_simul();
    test_empty_read();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_fifo.md
# ps2_ascii_fifo

Downstream consumer of the PS/2 receiver. Translates each accepted make-code (`scancode` qualified by the one-cycle `oflag` strobe, shift state from `on_shift`) into an 8-bit ASCII character and buffers it in a show-ahead FIFO. The RISC-V core reads the FIFO through the memory-mapped keyboard data and status registers. Characters survive until the program consumes them, decoupling key timing from software polling.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`; derived, never overridden.

- `clk`  in  1  system clock, same domain as the PS/2 receiver outputs.
- `reset`  in  1  asynchronous, active-high reset.
- `scancode`  in  8  make-code from the receiver; sampled only when `oflag`=1.
- `oflag`  in  1  one-cycle strobe, new make-code present.
- `on_shift`  in  1  level, a shift key is held.
- `rd_en`  in  1  one-cycle pop strobe from the bus decoder, issued on a data-register read.
- `clr_ovf`  in  1  one-cycle strobe, clears `overflow`.
- `rd_data`  out  8  ASCII at FIFO head; 8'h00 when empty.
- `valid`  out  1  FIFO non-empty.
- `count`  out  CNT_W  entries held, 0..DEPTH.
- `overflow`  out  1  sticky, a character was dropped because the FIFO was full.

## Operation
- Lookup is combinational on `scancode`/`on_shift`. The result `ascii`=8'h00 means unmapped.
- Push condition: `oflag` & (`ascii`≠0).
  - Unmapped codes are silently dropped; no overflow is raised.
- Mapped set:
  - letters 0x1C 'a', 0x32 'b', 0x21 'c', 0x23 'd', 0x24 'e' … (full set 2-row PS/2 set 2)
  - digits 0x45 '0', 0x16 '1' … 0x46 '9'
  - 0x29 space 8'h20, 0x5A enter 8'h0D, 0x66 backspace 8'h08, 0x0D tab 8'h09
  - 0x4E '-', 0x55 '=', 0x41 ',', 0x49 '.', 0x4A '/'
- Pop condition: `rd_en` & `valid`. `rd_en` while empty is ignored; state is unchanged.
- Push while full (no pop the same cycle): the character is dropped and `overflow` is set to 1.
- Push and pop in the same cycle:
  - when full: both are performed, `count` is unchanged, and `overflow` is not set.
  - when empty: only the push takes effect.
- `overflow` clears only on `clr_ovf` or reset. If `clr_ovf` and a new overflow coincide, the set wins.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty come from `count`.
- Storage is a register array. `rd_data` = `mem[rd_ptr]` gated by `valid`.

## Timing
- Reset (asynchronous, immediate):
  - `count`=0, `valid`=0, `rd_data`=8'h00, `overflow`=0, pointers=0.
  - Array contents are don't-care.
- Push latency: `oflag` in cycle N → `valid`/`count`/`rd_data` reflect the new entry in N+1.
- Pop latency: `rd_en` in cycle N → the next head (or 8'h00) is presented in N+1.
  - The bus samples `rd_data` in cycle N, the same cycle as `rd_en`.
- Reset asserted mid-operation discards all buffered characters. The first push after deassertion lands in entry 0.
- No back-pressure toward the receiver; `oflag` is never stalled.

## Configuration
- `KBD_SHIFT_MAP_EN`:
  - Defined: `on_shift`=1 selects the shifted table.
    - letters become uppercase (0x1C → 'A' 8'h41)
    - digits become symbols (0x16 → '!', 0x1E → '@', 0x45 → ')')
    - punctuation is shifted (0x4E → '_', 0x55 → '+')
    - space/enter/backspace/tab are unchanged
  - Undefined: `on_shift` is ignored (port kept, unused) and only the unshifted table exists.

## Structure
- Package `keyboard_pkg`:
  - named scancode constants (`SC_ENTER`, `SC_BKSP`, `SC_SPACE`, …)
  - ASCII constants (`ASCII_CR`=8'h0D, `ASCII_BS`=8'h08)
  - function `sc_to_ascii(input logic [7:0] sc, input logic shift)` holding both tables
- Sub-module `kbd_fifo`: generic show-ahead FIFO (params `WIDTH`, `DEPTH`; ports push/pop/din/dout/count/full/empty).
  - The top holds the lookup, the push/overflow logic, and the `rd_data` gating.

## Test plan
- Reset, then `oflag` with `scancode`=8'h1C, `on_shift`=0 → next cycle `valid`=1, `count`=1, `rd_data`=8'h61. `rd_en` one cycle → `valid`=0, `rd_data`=8'h00.
- With `KBD_SHIFT_MAP_EN`: `on_shift`=1 plus codes 8'h1C and 8'h16 → pops return 8'h41 then 8'h21. Without the macro the same stimulus returns 8'h61 then 8'h31.
- Push 8'h0E (unmapped) and 8'h5A → `count`=1, head 8'h0D, `overflow`=0.
- Push DEPTH+1 mapped codes (DEPTH=16) → `count`=16 and `overflow`=1. Draining 16 times yields the first 16 characters in order; the 17th is absent.
- At full, `oflag` and `rd_en` together → `count` stays 16, `overflow` stays 0 (after a `clr_ovf`), and the new character appears last when drained.
- `rd_en` on empty → nothing changes. Assert `reset` asynchronously with `count`=5 → outputs return to reset values before the next clock edge.
